ahb_lite_wbuf: RTL and testbench

AHB_LITE_WBUF -- requirements
Module: ahb_lite_wbuf

---
 rtl/ahb_lite_pkg.sv | 27 ++
 rtl/ahb_lite_wbuf_fifo.sv | 93 +++++++++
 rtl/ahb_lite_wbuf.sv | 214 +++++++++++++++++++++
 tb/tb_ahb_lite_wbuf.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg -- encodings shared by the AHB-Lite posted-write buffer.
//   slv_state_e : upstream (slave-side) FSM states
//   mst_state_e : downstream (master-side) FSM states
//   HTRANS_*    : AHB transfer-type codes
//   HSIZE_WORD  : 32-bit transfer size code
//   HBURST_SINGLE : single-beat burst code
package ahb_lite_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WR_FULL  = 2'd1,
      S_RD_DRAIN = 2'd2,
      S_RD_WAIT  = 2'd3
   } slv_state_e;

   typedef enum logic [1:0] {
      M_IDLE = 2'd0,
      M_ADDR = 2'd1,
      M_DATA = 2'd2
   } mst_state_e;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/ahb_lite_wbuf_fifo.sv
// ahb_lite_wbuf_fifo -- posted-write FIFO holding {address, data} entries.
// Optional macro AHB_WBUF_RD_FWD_EN adds an associative lookup of the newest
// buffered entry matching an address.
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   push, push_addr/data   : write an entry (accepted when full only if popping too)
//   pop                    : retire the head entry
//   head_addr, head_data   : oldest entry
//   full, empty            : occupancy flags
//   lookup_addr/hit/data   : (AHB_WBUF_RD_FWD_EN only) read-forward lookup
module ahb_lite_wbuf_fifo #(
   parameter int unsigned AW    = 25,
   parameter int unsigned DEPTH = 4
) (
   input  logic          HCLK,
   input  logic          HRESETn,
   input  logic          push,
   input  logic [AW-1:0] push_addr,
   input  logic [31:0]   push_data,
   input  logic          pop,
   output logic [AW-1:0] head_addr,
   output logic [31:0]   head_data,
   output logic          full,
`ifdef AHB_WBUF_RD_FWD_EN
   output logic          empty,
   input  logic [AW-1:0] lookup_addr,
   output logic          lookup_hit,
   output logic [31:0]   lookup_data
`else
   output logic          empty
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [AW-1:0] mem_addr [DEPTH];
   logic [31:0]   mem_data [DEPTH];
   logic          do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   // A push into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: entries are only visible through count_q.
   always_ff @(posedge HCLK) begin
      if (do_push) begin
         mem_addr[wr_ptr_q] <= push_addr;
         mem_data[wr_ptr_q] <= push_data;
      end
   end

   assign head_addr = mem_addr[rd_ptr_q];
   assign head_data = mem_data[rd_ptr_q];

`ifdef AHB_WBUF_RD_FWD_EN
   logic [PW-1:0] idx;

   // Walk oldest to newest so the last hit is the newest matching entry.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      idx         = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (mem_addr[idx] == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = mem_data[idx];
         end
      end
   end
`endif

endmodule

// File: rtl/ahb_lite_wbuf.sv
// ahb_lite_wbuf -- AHB-Lite posted-write buffer in front of an SDRAM controller.
// Writes are acknowledged with zero wait states while the FIFO has room and are
// replayed downstream in order; reads wait for the FIFO to drain, then go downstream.
// Optional macro AHB_WBUF_RD_FWD_EN: reads hitting a buffered entry are answered
// from the FIFO with zero wait states.
//   HCLK, HRESETn                 : clock, asynchronous active-low reset
//   HSEL..HWDATA                  : upstream AHB-Lite request (HSIZE/HBURST ignored)
//   HRDATA, HREADY, HRESP         : upstream response (HRESP always OKAY)
//   M_HSEL..M_HWDATA              : downstream request
//   M_HRDATA, M_HREADY            : downstream response
module ahb_lite_wbuf
   import ahb_lite_pkg::*;
#(
   parameter int unsigned HADDR_BITS = 25,
   parameter int unsigned DEPTH      = 4
) (
   input  logic                  HCLK,
   input  logic                  HRESETn,
   input  logic                  HSEL,
   input  logic [HADDR_BITS-1:0] HADDR,
   input  logic [1:0]            HTRANS,
   input  logic                  HWRITE,
   input  logic [2:0]            HSIZE,
   input  logic [2:0]            HBURST,
   input  logic [31:0]           HWDATA,
   output logic [31:0]           HRDATA,
   output logic                  HREADY,
   output logic                  HRESP,
   output logic                  M_HSEL,
   output logic [HADDR_BITS-1:0] M_HADDR,
   output logic [1:0]            M_HTRANS,
   output logic                  M_HWRITE,
   output logic [2:0]            M_HSIZE,
   output logic [2:0]            M_HBURST,
   output logic [31:0]           M_HWDATA,
   input  logic [31:0]           M_HRDATA,
   input  logic                  M_HREADY
);

   slv_state_e slv_q, slv_d;
   mst_state_e mst_q, mst_d;

   // Registered address phase
   logic                  dp_valid_q, dp_write_q;
   logic [HADDR_BITS-1:0] dp_addr_q;

   // Downstream access registers
   logic [HADDR_BITS-1:0] m_addr_q;
   logic                  m_write_q;
   logic [31:0]           m_wdata_q;
   logic                  m_load, m_load_write;
   logic [HADDR_BITS-1:0] m_load_addr;

   logic                  hready;
   logic [31:0]           hrdata;
   logic                  push, pop, rd_done, wr_ok;
   logic                  full, empty;
   logic [HADDR_BITS-1:0] head_addr;
   logic [31:0]           head_data;

   // Size, burst and the SEQ/NONSEQ distinction do not affect behaviour.
   logic unused_ok;
   assign unused_ok = ^{HSIZE, HBURST, HTRANS[0]};

`ifdef AHB_WBUF_RD_FWD_EN
   logic        fwd_hit;
   logic [31:0] fwd_data;
`endif

   ahb_lite_wbuf_fifo #(
      .AW    (HADDR_BITS),
      .DEPTH (DEPTH)
   ) u_fifo (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .push        (push),
      .push_addr   (dp_addr_q),
      .push_data   (HWDATA),
      .pop         (pop),
      .head_addr   (head_addr),
      .head_data   (head_data),
      .full        (full),
`ifdef AHB_WBUF_RD_FWD_EN
      .empty       (empty),
      .lookup_addr (dp_addr_q),
      .lookup_hit  (fwd_hit),
      .lookup_data (fwd_data)
`else
      .empty       (empty)
`endif
   );

   assign pop     = (mst_q == M_DATA) & M_HREADY & m_write_q;
   assign rd_done = (mst_q == M_DATA) & M_HREADY & ~m_write_q;
   // A full FIFO can still take a write in the cycle the head retires.
   assign wr_ok   = ~full | pop;

   // Slave FSM: next state and upstream response
   always_comb begin
      slv_d  = slv_q;
      hready = 1'b1;
      hrdata = '0;
      push   = 1'b0;
      case (slv_q)
         S_IDLE: begin
            if (dp_valid_q) begin
               if (dp_write_q) begin
                  if (wr_ok) begin
                     push = 1'b1;
                  end else begin
                     hready = 1'b0;
                     slv_d  = S_WR_FULL;
                  end
               end else begin
`ifdef AHB_WBUF_RD_FWD_EN
                  if (fwd_hit) begin
                     hrdata = fwd_data;
                  end else begin
                     hready = 1'b0;
                     slv_d  = empty ? S_RD_WAIT : S_RD_DRAIN;
                  end
`else
                  hready = 1'b0;
                  slv_d  = empty ? S_RD_WAIT : S_RD_DRAIN;
`endif
               end
            end
         end
         S_WR_FULL: begin
            hready = wr_ok;
            if (wr_ok) begin
               push  = 1'b1;
               slv_d = S_IDLE;
            end
         end
         S_RD_DRAIN: begin
            hready = 1'b0;
            if (empty) slv_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            hready = rd_done;
            if (rd_done) begin
               hrdata = M_HRDATA;
               slv_d  = S_IDLE;
            end
         end
         default: slv_d = S_IDLE;
      endcase
   end

   // Master FSM: buffered writes first, a read only once the FIFO is drained
   always_comb begin
      mst_d        = mst_q;
      m_load       = 1'b0;
      m_load_addr  = head_addr;
      m_load_write = 1'b1;
      case (mst_q)
         M_IDLE: begin
            if (!empty) begin
               m_load = 1'b1;
               mst_d  = M_ADDR;
            end else if (slv_q == S_RD_WAIT) begin
               m_load       = 1'b1;
               m_load_addr  = dp_addr_q;
               m_load_write = 1'b0;
               mst_d        = M_ADDR;
            end
         end
         M_ADDR:  mst_d = M_DATA;
         M_DATA:  if (M_HREADY) mst_d = M_IDLE;
         default: mst_d = M_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         slv_q      <= S_IDLE;
         mst_q      <= M_IDLE;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_addr_q  <= '0;
         m_addr_q   <= '0;
         m_write_q  <= 1'b0;
         m_wdata_q  <= '0;
      end else begin
         slv_q <= slv_d;
         mst_q <= mst_d;
         // Address phase is taken only when the previous data phase completes.
         if (hready) begin
            dp_valid_q <= HSEL & HTRANS[1];
            dp_write_q <= HWRITE;
            dp_addr_q  <= HADDR;
         end
         if (m_load) begin
            m_addr_q  <= m_load_addr;
            m_write_q <= m_load_write;
         end
         // Head is unchanged between load and M_ADDR, so this is the issued entry.
         if ((mst_q == M_ADDR) && m_write_q) m_wdata_q <= head_data;
      end
   end

   assign HREADY   = hready;
   assign HRDATA   = hrdata;
   assign HRESP    = 1'b0;
   assign M_HSEL   = (mst_q == M_ADDR);
   assign M_HTRANS = (mst_q == M_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
   assign M_HADDR  = m_addr_q;
   assign M_HWRITE = m_write_q;
   assign M_HSIZE  = HSIZE_WORD;
   assign M_HBURST = HBURST_SINGLE;
   assign M_HWDATA = m_wdata_q;

endmodule

// File: tb/tb_ahb_lite_wbuf.sv
// tb_ahb_lite_wbuf -- self-checking bench for ahb_lite_wbuf (DEPTH=4, 25-bit address).
// A table of single transfers checks data and wait-state behaviour; hand-written
// sequences cover the full FIFO, read-after-write and mid-transfer reset.
module tb_ahb_lite_wbuf;

   localparam int unsigned HAW = 25;

   logic            HCLK, HRESETn;
   logic            HSEL, HWRITE;
   logic [HAW-1:0]  HADDR;
   logic [1:0]      HTRANS;
   logic [2:0]      HSIZE, HBURST;
   logic [31:0]     HWDATA, HRDATA;
   logic            HREADY, HRESP;
   logic            M_HSEL, M_HWRITE, M_HREADY;
   logic [HAW-1:0]  M_HADDR;
   logic [1:0]      M_HTRANS;
   logic [2:0]      M_HSIZE, M_HBURST;
   logic [31:0]     M_HWDATA, M_HRDATA;

   int checks = 0;
   int failures = 0;

   ahb_lite_wbuf dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HSEL     (HSEL),
      .HADDR    (HADDR),
      .HTRANS   (HTRANS),
      .HWRITE   (HWRITE),
      .HSIZE    (HSIZE),
      .HBURST   (HBURST),
      .HWDATA   (HWDATA),
      .HRDATA   (HRDATA),
      .HREADY   (HREADY),
      .HRESP    (HRESP),
      .M_HSEL   (M_HSEL),
      .M_HADDR  (M_HADDR),
      .M_HTRANS (M_HTRANS),
      .M_HWRITE (M_HWRITE),
      .M_HSIZE  (M_HSIZE),
      .M_HBURST (M_HBURST),
      .M_HWDATA (M_HWDATA),
      .M_HRDATA (M_HRDATA),
      .M_HREADY (M_HREADY)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   // Downstream slave model and transfer log
   logic [31:0] mem_model [int unsigned];
   logic [31:0] log_addr [$];
   logic [31:0] log_data [$];
   bit          log_wr [$];
   int          issue_count = 0;
   int          rd_count = 0;
   bit          in_data = 1'b0;
   logic [31:0] cur_addr;
   bit          cur_wr;

   always @(negedge HCLK) begin
      if (!HRESETn) begin
         in_data = 1'b0;
      end else if (M_HSEL && (M_HTRANS == 2'b10)) begin
         cur_addr = 32'(M_HADDR);
         cur_wr   = M_HWRITE;
         in_data  = 1'b1;
         issue_count++;
         if (!M_HWRITE)
            M_HRDATA = mem_model.exists(cur_addr) ? mem_model[cur_addr]
                                                  : (32'hC0DE_0000 | cur_addr);
      end else if (in_data && M_HREADY) begin
         if (cur_wr) mem_model[cur_addr] = M_HWDATA;
         else        rd_count++;
         log_addr.push_back(cur_addr);
         log_data.push_back(M_HWDATA);
         log_wr.push_back(cur_wr);
         in_data = 1'b0;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   // One single transfer: address phase, then data phase until HREADY=1.
   task automatic xfer(input bit wr, input logic [HAW-1:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int ws);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HWRITE = wr;
      HADDR  = addr;
      step();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HWDATA = wdata;
      ws     = 0;
      @(negedge HCLK);
      while (!HREADY && ws < 200) begin
         ws++;
         @(negedge HCLK);
      end
      if (!HREADY) begin
         checks++;
         failures++;
         $display("FAIL xfer_timeout addr=%h: HREADY actual=0 required=1", addr);
      end
      rdata = HRDATA;
      step();
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_hready"},   32'(HREADY),   32'd1);
      chk({tag, "_hrdata"},   HRDATA,        32'd0);
      chk({tag, "_m_hsel"},   32'(M_HSEL),   32'd0);
      chk({tag, "_m_htrans"}, 32'(M_HTRANS), 32'd0);
      chk({tag, "_m_hwrite"}, 32'(M_HWRITE), 32'd0);
      chk({tag, "_m_haddr"},  32'(M_HADDR),  32'd0);
      chk({tag, "_m_hwdata"}, M_HWDATA,      32'd0);
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_stall;
      int          gap;
   } vec_t;

   vec_t vecs [9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rdata;
      int          ws, base, n, snap_log, snap_issue, snap_rd;

      // Writes never stall here; reads come after the FIFO has drained, so they
      // stall in both builds and fetch from the downstream model.
      vecs[0] = '{1'b1, 32'h010, 32'h1111_1111, 32'h0,          1'b0, 0};
      vecs[1] = '{1'b1, 32'h014, 32'h2222_2222, 32'h0,          1'b0, 0};
      vecs[2] = '{1'b1, 32'h018, 32'h3333_3333, 32'h0,          1'b0, 8};
      vecs[3] = '{1'b0, 32'h014, 32'h0,         32'h2222_2222,  1'b1, 0};
      vecs[4] = '{1'b0, 32'h010, 32'h0,         32'h1111_1111,  1'b1, 0};
      vecs[5] = '{1'b1, 32'h014, 32'h4444_4444, 32'h0,          1'b0, 8};
      vecs[6] = '{1'b0, 32'h014, 32'h0,         32'h4444_4444,  1'b1, 0};
      vecs[7] = '{1'b0, 32'h018, 32'h0,         32'h3333_3333,  1'b1, 0};
      vecs[8] = '{1'b0, 32'h01C, 32'h0,         32'hC0DE_001C,  1'b1, 0};

      HRESETn  = 1'b0;
      HSEL     = 1'b0;
      HADDR    = '0;
      HTRANS   = 2'b00;
      HWRITE   = 1'b0;
      HSIZE    = 3'b000;
      HBURST   = 3'b011;
      HWDATA   = '0;
      M_HREADY = 1'b1;
      idle(3);
      chk_reset_outputs("init");
      HRESETn = 1'b1;
      idle(2);

      // Table-driven single transfers
      for (int i = 0; i < 9; i++) begin
         xfer(vecs[i].wr, vecs[i].addr[HAW-1:0], vecs[i].wdata, rdata, ws);
         chk($sformatf("vec%0d_stall", i), 32'(ws != 0), 32'(vecs[i].exp_stall));
         if (!vecs[i].wr) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
         idle(vecs[i].gap);
      end
      idle(10);

      // Back-to-back writes with the downstream stalled, then a fifth into a full FIFO
      base     = log_wr.size();
      M_HREADY = 1'b0;
      for (int i = 0; i < 5; i++) begin
         HSEL   = 1'b1;
         HTRANS = 2'b10;
         HWRITE = 1'b1;
         HADDR  = HAW'(32'h100 + i);
         if (i > 0) HWDATA = 32'hA0 + 32'(i - 1);
         @(negedge HCLK);
         chk($sformatf("b2b_hready_%0d", i), 32'(HREADY), 32'd1);
         step();
      end
      HSEL   = 1'b0;
      HTRANS = 2'b00;
      HWRITE = 1'b0;
      HWDATA = 32'hA4;
      @(negedge HCLK);
      chk("full_stall_0", 32'(HREADY), 32'd0);
      chk("full_count", 32'(dut.u_fifo.count_q), 32'd4);
      step();
      @(negedge HCLK);
      chk("full_stall_1", 32'(HREADY), 32'd0);
      step();
      M_HREADY = 1'b1;
      @(negedge HCLK);
      chk("pop_cycle_hready", 32'(HREADY), 32'd1);
      step();
      @(negedge HCLK);
      chk("push_pop_count", 32'(dut.u_fifo.count_q), 32'd4);
      step();
      n = 0;
      while (log_wr.size() < base + 5 && n < 200) begin
         step();
         n++;
      end
      chk("b2b_write_count", 32'(log_wr.size() - base), 32'd5);
      for (int k = 0; k < 5; k++) begin
         if (base + k < log_wr.size()) begin
            chk($sformatf("b2b_addr_%0d", k), log_addr[base + k], 32'h100 + 32'(k));
            chk($sformatf("b2b_data_%0d", k), log_data[base + k], 32'hA0 + 32'(k));
         end
      end
      idle(5);

      // Write then read of the same address
      snap_rd = rd_count;
      xfer(1'b1, HAW'(32'h200), 32'hDEAD_BEEF, rdata, ws);
      chk("raw_write_stall", 32'(ws != 0), 32'd0);
      xfer(1'b0, HAW'(32'h200), 32'h0, rdata, ws);
      chk("raw_rdata", rdata, 32'hDEAD_BEEF);
      idle(12);
`ifdef AHB_WBUF_RD_FWD_EN
      chk("raw_fwd_stall", 32'(ws != 0), 32'd0);
      chk("raw_fwd_no_rd", 32'(rd_count - snap_rd), 32'd0);
`else
      chk("raw_stall", 32'(ws != 0), 32'd1);
      chk("raw_rd_count", 32'(rd_count - snap_rd), 32'd1);
      n = log_wr.size();
      if (n >= 2) begin
         chk("raw_first_is_wr", 32'(log_wr[n - 2]), 32'd1);
         chk("raw_first_addr",  log_addr[n - 2],    32'h200);
         chk("raw_then_rd",     32'(log_wr[n - 1]), 32'd0);
         chk("raw_rd_addr",     log_addr[n - 1],    32'h200);
      end
`endif

      // Reset with three buffered writes and a stalled downstream data phase
      M_HREADY = 1'b0;
      xfer(1'b1, HAW'(32'h300), 32'h3000_0001, rdata, ws);
      xfer(1'b1, HAW'(32'h304), 32'h3000_0002, rdata, ws);
      xfer(1'b1, HAW'(32'h308), 32'h3000_0003, rdata, ws);
      idle(3);
      chk("pre_reset_m_hwrite", 32'(M_HWRITE), 32'd1);
      snap_log   = log_wr.size();
      snap_issue = issue_count;
      HRESETn    = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      chk("midrst_count", 32'(dut.u_fifo.count_q), 32'd0);
      M_HREADY = 1'b1;
      idle(2);
      HRESETn = 1'b1;
      idle(20);
      chk("post_reset_issues", 32'(issue_count - snap_issue), 32'd0);
      chk("post_reset_completions", 32'(log_wr.size() - snap_log), 32'd0);
      chk("post_reset_hready", 32'(HREADY), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
